// File: rtl/scr1_dmem_responder.sv
// Memory-side responder for the SCR1 data-memory interface.
// Accepts pipelined requests, holds them in an in-order queue for a fixed latency,
// then answers each one for exactly one cycle with OKAY/ERROR. An LFSR can stall
// req_ack pseudo-randomly so fuzzing tops see repeatable backpressure.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   dmem_req/cmd/width/addr/wdata  address-phase request from the core
//   dmem_req_ack      combinational accept for the current cycle
//   dmem_rdata/resp   response phase, driven from registered queue state
//   busy              registered "queue non-empty" flag
module scr1_dmem_responder #(
  parameter int unsigned AWIDTH       = 32,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned RESP_LATENCY = 1,
  parameter int unsigned QDEPTH       = 4,
  parameter bit          STALL_EN     = 1'b1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmem_req,
  input  logic              dmem_cmd,
  input  logic [1:0]        dmem_width,
  input  logic [AWIDTH-1:0] dmem_addr,
  input  logic [DWIDTH-1:0] dmem_wdata,
  output logic              dmem_req_ack,
  output logic [DWIDTH-1:0] dmem_rdata,
  output logic [1:0]        dmem_resp,
  output logic              busy
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] W_BYTE     = 2'd0;
  localparam logic [1:0] W_HWORD    = 2'd1;
  localparam logic [1:0] W_WORD     = 2'd2;
  localparam logic [1:0] W_ERROR    = 2'd3;
  localparam logic [1:0] RESP_IDLE  = 2'd0;
  localparam logic [1:0] RESP_OKAY  = 2'd1;
  localparam logic [1:0] RESP_ERROR = 2'd2;
  localparam logic [1:0] TIMER_INIT = 2'(RESP_LATENCY - 1);

  typedef struct packed {
    logic              cmd;
    logic [1:0]        width;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic [1:0]        timer;
  } entry_t;

  entry_t            q_q [QDEPTH];
  entry_t            q_d [QDEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              busy_q, busy_d;
  logic [DWIDTH-1:0] mem [MEM_WORDS];

  logic              stall_c;
  logic              push_c;
  logic              pop_c;
  logic              err_c;
  entry_t            head_c;
  logic [IW-1:0]     widx_c;
  logic [3:0]        be_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Head-of-queue decode: pop readiness, error class, word index and byte enables
  always_comb begin
    head_c  = q_q[rd_ptr_q];
    stall_c = STALL_EN & lfsr_q[0] & lfsr_q[1];
    // pre-pop count: a full queue never accepts, even on a pop cycle
    dmem_req_ack = !rst && !stall_c && (count_q < CW'(QDEPTH));
    push_c  = dmem_req && dmem_req_ack;
    pop_c   = !rst && (count_q != '0) && (head_c.timer == 2'd0);
    err_c   = (head_c.width == W_ERROR)
           || ((head_c.width == W_HWORD) && head_c.addr[0])
           || ((head_c.width == W_WORD) && (head_c.addr[1:0] != 2'b00))
           || (64'(head_c.addr) >= 64'(MEM_WORDS) * 64'd4);
    widx_c  = head_c.addr[IW+1:2];
    be_c    = 4'b1111;
    case (head_c.width)
      W_BYTE:  be_c = 4'b0001 << head_c.addr[1:0];
      W_HWORD: be_c = 4'b0011 << head_c.addr[1:0];
      default: be_c = 4'b1111;
    endcase
  end

  // Response phase lasts exactly the cycle in which the head pops
  always_comb begin
    dmem_resp  = RESP_IDLE;
    dmem_rdata = '0;
    if (pop_c) begin
      dmem_resp = err_c ? RESP_ERROR : RESP_OKAY;
      if (!err_c && !head_c.cmd) begin
        dmem_rdata = mem[widx_c];
      end
    end
  end

  // Queue, timer and LFSR next-state
  always_comb begin
    q_d      = q_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Fibonacci x^16+x^14+x^13+x^11+1, right-shifting form
    lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_q[i].timer != 2'd0) begin
        q_d[i].timer = q_q[i].timer - 2'd1;
      end
    end
    if (push_c) begin
      q_d[wr_ptr_q].cmd   = dmem_cmd;
      q_d[wr_ptr_q].width = dmem_width;
      q_d[wr_ptr_q].addr  = dmem_addr;
      q_d[wr_ptr_q].wdata = dmem_wdata;
      q_d[wr_ptr_q].timer = TIMER_INIT;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    busy_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      busy_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      lfsr_q   <= lfsr_d;
      busy_q   <= busy_d;
    end
  end

  // Backing store: writes commit in order at the response edge, never reset
  always_ff @(posedge clk) begin
    if (pop_c && !err_c && head_c.cmd) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) begin
          mem[widx_c][8*i +: 8] <= head_c.wdata[8*i +: 8];
        end
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_scr1_dmem_responder.sv
module tb_scr1_dmem_responder;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    logic        cmd;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          due;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_s   [3];
  logic        cmd_s   [3];
  logic [1:0]  width_s [3];
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic        ack     [3];
  logic [31:0] rdata   [3];
  logic [1:0]  resp    [3];
  logic        busy    [3];

  int lat_a [3] = '{1, 4, 2};
  int qd_a  [3] = '{4, 8, 4};
  int stl_a [3] = '{0, 0, 1};

  sb_t         sb[$];
  logic [31:0] mm [3][1024];
  logic [15:0] lf = SEED;
  logic        acc;
  int          sel = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  scr1_dmem_responder #(.RESP_LATENCY(1), .QDEPTH(4), .STALL_EN(1'b0)) u_lat1 (
    .clk(clk), .rst(rst), .dmem_req(req_s[0]), .dmem_cmd(cmd_s[0]), .dmem_width(width_s[0]),
    .dmem_addr(addr_s[0]), .dmem_wdata(wdata_s[0]), .dmem_req_ack(ack[0]),
    .dmem_rdata(rdata[0]), .dmem_resp(resp[0]), .busy(busy[0]));

  scr1_dmem_responder #(.RESP_LATENCY(4), .QDEPTH(8), .STALL_EN(1'b0)) u_lat4 (
    .clk(clk), .rst(rst), .dmem_req(req_s[1]), .dmem_cmd(cmd_s[1]), .dmem_width(width_s[1]),
    .dmem_addr(addr_s[1]), .dmem_wdata(wdata_s[1]), .dmem_req_ack(ack[1]),
    .dmem_rdata(rdata[1]), .dmem_resp(resp[1]), .busy(busy[1]));

  scr1_dmem_responder #(.RESP_LATENCY(2), .QDEPTH(4), .STALL_EN(1'b1), .LFSR_SEED(SEED)) u_stall (
    .clk(clk), .rst(rst), .dmem_req(req_s[2]), .dmem_cmd(cmd_s[2]), .dmem_width(width_s[2]),
    .dmem_addr(addr_s[2]), .dmem_wdata(wdata_s[2]), .dmem_req_ack(ack[2]),
    .dmem_rdata(rdata[2]), .dmem_resp(resp[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // One clock: check the selected DUT at the negedge, then advance the reference models
  task automatic tick();
    logic        exp_ack;
    logic        err;
    logic [31:0] exp_rd;
    logic [3:0]  be;
    int          w;
    sb_t         e;
    @(negedge clk);
    exp_ack = !rst && !((stl_a[sel] != 0) && lf[0] && lf[1]) && (sb.size() < qd_a[sel]);
    chk("req_ack", 32'(ack[sel]), 32'(exp_ack));
    chk("busy", 32'(busy[sel]), 32'(sb.size() != 0));
    if (!rst && sb.size() != 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      chk("resp_cycle", 32'(cyc), 32'(e.due));
      err = (e.width == 2'd3) || (e.width == 2'd1 && e.addr[0])
         || (e.width == 2'd2 && e.addr[1:0] != 2'b00) || (e.addr >= 32'h1000);
      exp_rd = 32'h0;
      if (!err) begin
        w = int'(e.addr[11:2]);
        if (e.cmd) begin
          case (e.width)
            2'd0:    be = 4'b0001 << e.addr[1:0];
            2'd1:    be = 4'b0011 << e.addr[1:0];
            default: be = 4'b1111;
          endcase
          for (int i = 0; i < 4; i++) if (be[i]) mm[sel][w][8*i +: 8] = e.wdata[8*i +: 8];
        end else begin
          exp_rd = mm[sel][w];
        end
      end
      chk("resp_code", 32'(resp[sel]), err ? 32'd2 : 32'd1);
      chk("resp_rdata", rdata[sel], exp_rd);
    end else begin
      chk("idle_resp", 32'(resp[sel]), 32'd0);
      chk("idle_rdata", rdata[sel], 32'd0);
    end
    acc = req_s[sel] && exp_ack;
    if (acc) begin
      sb.push_back('{cmd: cmd_s[sel], width: width_s[sel], addr: addr_s[sel],
                     wdata: wdata_s[sel], due: cyc + lat_a[sel]});
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      lf = SEED;
      sb.delete();
    end else begin
      lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
    end
    #1;
  endtask

  task automatic req_go(input logic c, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, output int n);
    cmd_s[sel] = c; width_s[sel] = w; addr_s[sel] = a; wdata_s[sel] = d;
    req_s[sel] = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 64) begin
      tick();
      n++;
    end
    chk("accept_bound", 32'(acc), 32'd1);
    req_s[sel] = 1'b0;
  endtask

  task automatic go(input logic c, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    int n;
    req_go(c, w, a, d, n);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(sb.size()), 32'd0);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_s[k] = 1'b0; cmd_s[k] = 1'b0; width_s[k] = 2'd0; addr_s[k] = '0; wdata_s[k] = '0;
    end
    for (int k = 0; k < 3; k++) for (int i = 0; i < 1024; i++) mm[k][i] = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // latency 1: write then read back, back-to-back
    sel = 0;
    go(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    go(1'b0, 2'd2, 32'h10, 32'h0);
    drain();
    // byte merge into an existing word
    go(1'b1, 2'd2, 32'h20, 32'h11223344);
    go(1'b1, 2'd0, 32'h21, 32'h0000AB00);
    go(1'b0, 2'd2, 32'h20, 32'h0);
    drain();
    chk("byte_merge_model", mm[0][8], 32'h1122AB44);
    // error classes; memory must stay untouched
    go(1'b1, 2'd2, 32'h100, 32'h0BADF00D);
    go(1'b0, 2'd1, 32'h03, 32'h0);
    go(1'b1, 2'd2, 32'h102, 32'hFFFFFFFF);
    go(1'b0, 2'd3, 32'h100, 32'h0);
    go(1'b0, 2'd2, 32'h1000, 32'h0);
    go(1'b0, 2'd2, 32'h100, 32'h0);
    go(1'b1, 2'd1, 32'h22, 32'h55660000);
    go(1'b0, 2'd2, 32'h20, 32'h0);
    drain();

    // latency 4: six back-to-back reads, ack must never drop
    sel = 1;
    for (int i = 0; i < 6; i++) go(1'b1, 2'd2, 32'(32'h200 + 4 * i), 32'(32'hA0000000 + i));
    drain();
    for (int i = 0; i < 6; i++) begin
      req_go(1'b0, 2'd2, 32'(32'h200 + 4 * i), 32'h0, n);
      chk("b2b_ack", 32'(n), 32'd1);
    end
    drain();

    // reset with three pending transactions including a write
    go(1'b1, 2'd2, 32'h40, 32'h55AA55AA);
    drain();
    go(1'b0, 2'd2, 32'h40, 32'h0);
    go(1'b1, 2'd2, 32'h40, 32'h12345678);
    go(1'b0, 2'd2, 32'h44, 32'h0);
    chk("pending_before_rst", 32'(sb.size()), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("busy_after_rst", 32'(busy[1]), 32'd0);
    repeat (8) tick();
    go(1'b0, 2'd2, 32'h40, 32'h0);
    drain();
    chk("rst_write_dropped", mm[1][16], 32'h55AA55AA);

    // stalled instance: preload, then 200 random requests
    sel = 2;
    for (int i = 0; i < 16; i++) go(1'b1, 2'd2, 32'(4 * i), $urandom);
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'(32'h1000 + $urandom_range(0, 255))
                                      : 32'($urandom_range(0, 63));
      go(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
      repeat ($urandom_range(0, 1)) tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
